// File: rtl/game_flow_ctrl.sv
// Game-flow controller: START/PLAY/LOSE/WIN/PAUSE sequencing with levels, lives,
// hit grace window and a BCD per-level countdown for the 7-segment driver.
module game_flow_ctrl #(
   parameter int CLK_HZ       = 100000000,
   parameter int TIME_LIMIT_S = 60,
   parameter int LIVES        = 3,
   parameter int LEVELS       = 3,
   parameter int GRACE_CYC    = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause_toggle,
   input  logic       hit,
   input  logic       goal,
   output logic [2:0] state,
   output logic [1:0] state_legacy,
   output logic       run,
   output logic [3:0] level,
   output logic [3:0] lives,
   output logic [3:0] time_tens,
   output logic [3:0] time_ones,
   output logic       sec_tick,
   output logic       grace
);

   localparam logic [2:0] ST_START = 3'd0;
   localparam logic [2:0] ST_PLAY  = 3'd1;
   localparam logic [2:0] ST_LOSE  = 3'd2;
   localparam logic [2:0] ST_WIN   = 3'd3;
   localparam logic [2:0] ST_PAUSE = 3'd4;

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int GW = $clog2(GRACE_CYC + 1);

   localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
   localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYC);
   localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
   localparam logic [3:0]    LEVEL_LAST = 4'(LEVELS);
   localparam logic [3:0]    TENS_INIT  = 4'(TIME_LIMIT_S / 10);
   localparam logic [3:0]    ONES_INIT  = 4'(TIME_LIMIT_S % 10);

   logic [2:0]    state_reg, state_next;
   logic [3:0]    level_reg, level_next;
   logic [3:0]    lives_reg, lives_next;
   logic [3:0]    tens_reg, tens_next;
   logic [3:0]    ones_reg, ones_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [GW-1:0] grace_cnt_reg, grace_cnt_next;
   logic          tick_reg, tick_next;

   logic tick_now;
   logic last_sec;
   logic hit_counted;
   logic hit_lethal;
   logic timeout;
   logic pausing;

   // Saturating BCD decrement of a two-digit seconds value.
   function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
      logic [7:0] r;
      if (o != 4'd0)
         r = {t, o - 4'd1};
      else if (t != 4'd0)
         r = {t - 4'd1, 4'd9};
      else
         r = 8'h00;
      return r;
   endfunction

   assign tick_now    = (presc_reg == PRESC_MAX);
   assign last_sec    = (tens_reg == 4'd0) && (ones_reg == 4'd1);
   assign hit_counted = hit && (grace_cnt_reg == '0);
   assign hit_lethal  = hit_counted && (lives_reg == 4'd1);
   assign timeout     = tick_now && last_sec;
   assign pausing     = pause_toggle && !goal && !hit_lethal && !timeout;

   always_comb begin
      state_next     = state_reg;
      level_next     = level_reg;
      lives_next     = lives_reg;
      tens_next      = tens_reg;
      ones_next      = ones_reg;
      presc_next     = presc_reg;
      grace_cnt_next = grace_cnt_reg;
      tick_next      = 1'b0;

      case (state_reg)
         ST_START: begin
            if (start) begin
               state_next     = ST_PLAY;
               level_next     = 4'd1;
               lives_next     = LIVES_INIT;
               tens_next      = TENS_INIT;
               ones_next      = ONES_INIT;
               presc_next     = '0;
               grace_cnt_next = '0;
            end
         end

         ST_PLAY: begin
            if (goal) begin
               // Goal outranks everything; clearing the last level freezes the clock.
               if (level_reg >= LEVEL_LAST) begin
                  state_next = ST_WIN;
               end else begin
                  level_next     = level_reg + 4'd1;
                  tens_next      = TENS_INIT;
                  ones_next      = ONES_INIT;
                  presc_next     = '0;
                  grace_cnt_next = '0;
               end
            end else begin
               // Entering PAUSE freezes the prescaler and grace window on that same cycle.
               if (!pausing) begin
                  if (tick_now) begin
                     presc_next             = '0;
                     tick_next              = 1'b1;
                     {tens_next, ones_next} = bcd_dec(tens_reg, ones_reg);
                  end else begin
                     presc_next = presc_reg + 1'b1;
                  end
                  if (grace_cnt_reg != '0)
                     grace_cnt_next = grace_cnt_reg - 1'b1;
               end

               if (hit_counted) begin
                  if (hit_lethal) begin
                     lives_next = 4'd0;
                     state_next = ST_LOSE;
                  end else begin
                     lives_next     = lives_reg - 4'd1;
                     grace_cnt_next = GRACE_LOAD;
                  end
               end

               if (timeout)
                  state_next = ST_LOSE;
               else if (pausing)
                  state_next = ST_PAUSE;
            end
         end

         ST_PAUSE: begin
            if (pause_toggle)
               state_next = ST_PLAY;
         end

         ST_LOSE, ST_WIN: begin
            if (start) begin
               state_next     = ST_START;
               level_next     = 4'd1;
               lives_next     = LIVES_INIT;
               tens_next      = TENS_INIT;
               ones_next      = ONES_INIT;
               presc_next     = '0;
               grace_cnt_next = '0;
            end
         end

         default: begin
            state_next = ST_START;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_START;
         level_reg     <= 4'd1;
         lives_reg     <= LIVES_INIT;
         tens_reg      <= TENS_INIT;
         ones_reg      <= ONES_INIT;
         presc_reg     <= '0;
         grace_cnt_reg <= '0;
         tick_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         level_reg     <= level_next;
         lives_reg     <= lives_next;
         tens_reg      <= tens_next;
         ones_reg      <= ones_next;
         presc_reg     <= presc_next;
         grace_cnt_reg <= grace_cnt_next;
         tick_reg      <= tick_next;
      end
   end

   assign state        = state_reg;
   assign state_legacy = (state_reg == ST_PAUSE) ? 2'd1 : state_reg[1:0];
   assign run          = (state_reg == ST_PLAY);
   assign level        = level_reg;
   assign lives        = lives_reg;
   assign time_tens    = tens_reg;
   assign time_ones    = ones_reg;
   assign sec_tick     = tick_reg;
   assign grace        = (grace_cnt_reg != '0);

endmodule
